// File: rtl/bp_pkg.sv
// Shared types and indexing for the correlating branch predictor.
// BP_GSHARE_EN selects gshare (XOR) indexing instead of {hist, pc}.
package bp_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'd0;
  localparam cnt_t CNT_WNT = 2'd1;
  localparam cnt_t CNT_WT  = 2'd2;
  localparam cnt_t CNT_ST  = 2'd3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Table index from a PC and a zero-extended history snapshot.
  function automatic logic [31:0] bp_index(
    input logic [31:0] pc,
    input logic [7:0]  hist,
    input int          abits
  );
    logic [31:0] p;
    p = (pc >> 2) & ((32'd1 << abits) - 32'd1);
`ifdef BP_GSHARE_EN
    return p ^ {24'd0, hist};
`else
    return p | ({24'd0, hist} << abits);
`endif
  endfunction

endpackage

// File: rtl/branch_history_predictor_sat.sv
// Next value of a 2-bit saturating counter.
// Taken counts up to 3, not-taken counts down to 0.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] nxt
);

  // Saturating increment / decrement.
  always_comb begin
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) nxt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_predictor.sv
// Two-level correlating predictor: one counter table, global history.
// BP_GSHARE_EN: index = pc ^ hist, depth 2^ADDR_BITS.
module branch_history_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int HIST_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  input  logic [31:0]          fetchPc,
  output logic                 fetchPredict,
  output logic [HIST_BITS-1:0] fetchHist,
  input  logic [31:0]          robPc,
  input  logic [HIST_BITS-1:0] robHist,
  output logic [1:0]           robCounter,
  input  logic                 updEn,
  input  logic [31:0]          updPc,
  input  logic [HIST_BITS-1:0] updHist,
  input  logic                 updTaken
);

`ifdef BP_GSHARE_EN
  localparam int IW = ADDR_BITS;
`else
  localparam int IW = ADDR_BITS + HIST_BITS;
`endif
  localparam int DEPTH = 1 << IW;

  state_e               state_q, state_d;
  logic [IW-1:0]        clr_idx_q, clr_idx_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic                 ready_q, ready_d;

  cnt_t tbl_q [DEPTH];

  logic [IW-1:0] fetch_idx, rob_idx, upd_idx;
  cnt_t          upd_cur, upd_next;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  cnt_t          wr_val;

  // Index computation for the three table ports.
  always_comb begin
    fetch_idx = IW'(bp_index(fetchPc, 8'(ghr_q), ADDR_BITS));
    rob_idx   = IW'(bp_index(robPc, 8'(robHist), ADDR_BITS));
    upd_idx   = IW'(bp_index(updPc, 8'(updHist), ADDR_BITS));
    upd_cur   = tbl_q[upd_idx];
  end

  sat_counter2 u_sat (
    .cnt   (upd_cur),
    .taken (updTaken),
    .nxt   (upd_next)
  );

  // Control state: clear sweep, then history tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      ghr_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ghr_q     <= ghr_d;
      ready_q   <= ready_d;
    end
  end

  // Next state: sweep indices in INIT, shift GHR on commits in RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ghr_d     = ghr_q;
    ready_d   = (state_q == RUN);
    unique case (state_q)
      INIT: begin
        clr_idx_d = clr_idx_q + IW'(1);
        if (clr_idx_q == '1) state_d = RUN;
      end
      RUN: begin
        if (updEn) ghr_d = HIST_BITS'({ghr_q, updTaken});
      end
      default: ;
    endcase
  end

  // Table write port: clear value in INIT, trained value in RUN.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = clr_idx_q;
    wr_val = CNT_WNT;
    unique case (state_q)
      INIT: wr_en = 1'b1;
      RUN: begin
        wr_en  = updEn;
        wr_idx = upd_idx;
        wr_val = upd_next;
      end
      default: ;
    endcase
  end

  // Table storage; contents are defined only after the clear sweep.
  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[wr_idx] <= wr_val;
  end

  // Read outputs; INIT masks the not-yet-cleared table.
  always_comb begin
    fetchPredict = 1'b0;
    robCounter   = CNT_WNT;
    if (state_q == RUN) begin
      fetchPredict = tbl_q[fetch_idx][1];
      robCounter   = tbl_q[rob_idx];
    end
  end

  assign fetchHist = ghr_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed + random bench for branch_history_predictor.
// Reference: array of ints indexed by arithmetic on PC/history.
module tb_branch_history_predictor;

  localparam int AB = 4;
  localparam int HB = 2;
`ifdef BP_GSHARE_EN
  localparam int DEPTH = 1 << AB;
`else
  localparam int DEPTH = 1 << (AB + HB);
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ready;
  logic [31:0]   fetchPc;
  logic          fetchPredict;
  logic [HB-1:0] fetchHist;
  logic [31:0]   robPc;
  logic [HB-1:0] robHist;
  logic [1:0]    robCounter;
  logic          updEn;
  logic [31:0]   updPc;
  logic [HB-1:0] updHist;
  logic          updTaken;

  int mdl [DEPTH];
  int ghr_m;
  int n_asr = 0;
  int n_fail = 0;

  branch_history_predictor #(.ADDR_BITS(AB), .HIST_BITS(HB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ready        (ready),
    .fetchPc      (fetchPc),
    .fetchPredict (fetchPredict),
    .fetchHist    (fetchHist),
    .robPc        (robPc),
    .robHist      (robHist),
    .robCounter   (robCounter),
    .updEn        (updEn),
    .updPc        (updPc),
    .updHist      (updHist),
    .updTaken     (updTaken)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int midx(logic [31:0] pc, int h);
    int p;
    p = int'((pc / 4) % (1 << AB));
`ifdef BP_GSHARE_EN
    return p ^ h;
`else
    return h * (1 << AB) + p;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asr++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply(logic [31:0] pc, int h, int t);
    int i;
    i = midx(pc, h);
    if (t != 0) mdl[i] = (mdl[i] < 3) ? mdl[i] + 1 : 3;
    else        mdl[i] = (mdl[i] > 0) ? mdl[i] - 1 : 0;
    ghr_m = (ghr_m * 2 + t) % (1 << HB);
  endtask

  task automatic upd(logic [31:0] pc, int h, int t);
    updPc = pc;
    updHist = HB'(h);
    updTaken = (t != 0);
    updEn = 1'b1;
    @(posedge clk);
    model_apply(pc, h, t);
    #1;
    updEn = 1'b0;
  endtask

  task automatic rob_chk(string tag, logic [31:0] pc, int h);
    robPc = pc;
    robHist = HB'(h);
    #1;
    chk(tag, 32'(robCounter), 32'(mdl[midx(pc, h)]));
  endtask

  task automatic fetch_chk(string tag, logic [31:0] pc);
    fetchPc = pc;
    #1;
    chk(tag, 32'(fetchPredict), 32'(mdl[midx(pc, ghr_m)] / 2));
    chk("fetch_hist", 32'(fetchHist), 32'(ghr_m));
  endtask

  // Run the clear sweep after reset release, optionally poking updEn.
  task automatic run_init(bit noise);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      if (noise && k <= DEPTH) begin
        updEn = 1'b1;
        updPc = $urandom;
        updHist = HB'($urandom);
        updTaken = 1'($urandom);
      end else begin
        updEn = 1'b0;
      end
      step();
      chk("ready_init", 32'(ready), 32'(k == DEPTH + 1));
    end
    updEn = 1'b0;
    chk("ghr_after_init", 32'(fetchHist), 32'd0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 1;
    ghr_m = 0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef BP_GSHARE_EN
      rob_chk("clear", 32'(i * 4), 0);
`else
      rob_chk("clear", 32'((i % (1 << AB)) * 4), i / (1 << AB));
`endif
    end
  endtask

  initial begin
    int v;
    rst_n = 1'b0;
    updEn = 1'b0;
    updPc = '0;
    updHist = '0;
    updTaken = 1'b0;
    fetchPc = 32'h40;
    robPc = 32'h40;
    robHist = '0;
    ghr_m = 0;
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_hist", 32'(fetchHist), 32'd0);
    chk("rst_pred", 32'(fetchPredict), 32'd0);
    chk("rst_rob", 32'(robCounter), 32'd1);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    run_init(1'b0);

    // Saturation up
    upd(32'h40, 0, 1);
    rob_chk("sat_up1", 32'h40, 0);
    chk("sat_up1_lit", 32'(robCounter), 32'd2);
    upd(32'h40, 0, 1);
    rob_chk("sat_up2", 32'h40, 0);
    chk("sat_up2_lit", 32'(robCounter), 32'd3);
    upd(32'h40, 0, 1);
    rob_chk("sat_up3", 32'h40, 0);
    chk("sat_up3_lit", 32'(robCounter), 32'd3);
    // Two not-taken elsewhere bring the GHR back to 0
    upd(32'h100, 1, 0);
    upd(32'h100, 1, 0);
    fetch_chk("pred_40", 32'h40);
    chk("pred_40_lit", 32'(fetchPredict), 32'd1);
    // Saturation down
    for (int k = 0; k < 4; k++) begin
      upd(32'h40, 0, 0);
      rob_chk("sat_dn", 32'h40, 0);
    end
    chk("sat_dn_lit", 32'(robCounter), 32'd0);

    // GHR shift
    upd(32'h8, 2, 1);
    fetch_chk("ghr_t", 32'h8);
    upd(32'h8, 2, 0);
    fetch_chk("ghr_n", 32'h8);
    chk("ghr_10", 32'(fetchHist), 32'd2);
    upd(32'h8, 2, 1);
    fetch_chk("ghr_t2", 32'h8);
    chk("ghr_01", 32'(fetchHist), 32'd1);

    // History separation
    v = mdl[midx(32'h40, 0)];
    upd(32'h40, 3, 1);
    rob_chk("hist_sep", 32'h40, 0);
    chk("hist_sep_lit", 32'(robCounter), 32'(v));
    rob_chk("hist_sep3", 32'h40, 3);

    // Same-cycle read/write at 0x80
    while (mdl[midx(32'h80, 0)] != 1)
      upd(32'h80, 0, (mdl[midx(32'h80, 0)] > 1) ? 0 : 1);
    robPc = 32'h80;
    robHist = '0;
    updPc = 32'h80;
    updHist = '0;
    updTaken = 1'b1;
    updEn = 1'b1;
    #1;
    chk("same_cycle_pre", 32'(robCounter), 32'd1);
    @(posedge clk);
    model_apply(32'h80, 0, 1);
    #1;
    updEn = 1'b0;
    rob_chk("same_cycle_post", 32'h80, 0);
    chk("same_cycle_post_lit", 32'(robCounter), 32'd2);
    // Back-to-back from 1
    upd(32'h80, 0, 0);
    updTaken = 1'b1;
    updEn = 1'b1;
    @(posedge clk);
    model_apply(32'h80, 0, 1);
    @(posedge clk);
    model_apply(32'h80, 0, 1);
    #1;
    updEn = 1'b0;
    rob_chk("b2b", 32'h80, 0);
    chk("b2b_lit", 32'(robCounter), 32'd3);

    // Random traffic, full 32-bit PCs exercise aliasing
    for (int k = 0; k < 300; k++) begin
      upd($urandom, int'($urandom_range(0, (1 << HB) - 1)),
          int'($urandom_range(0, 1)));
      rob_chk("rnd_rob", $urandom, int'($urandom_range(0, (1 << HB) - 1)));
      fetch_chk("rnd_fetch", $urandom);
    end

    // Reset mid-operation
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_hist", 32'(fetchHist), 32'd0);
    chk("mid_rst_pred", 32'(fetchPredict), 32'd0);
    chk("mid_rst_rob", 32'(robCounter), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_init(1'b1);
    fetch_chk("post_rst_fetch", 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asr, n_fail);
    $finish;
  end

endmodule
